// File: rtl/imm_gen_pkg.sv
// Shared opcodes, format codes, occupancy states and the immediate extend
// helper for the immediate-generation stage.
package imm_gen_pkg;

   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_FENCE     = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_CSR  = 3'd6
   } fmt_e;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } occ_e;

   // Widens a 32-bit immediate to the widest XLEN; callers size-cast to XLEN.
   function automatic logic [63:0] extend_imm(input logic [31:0] val, input logic sgn);
      return {{32{sgn & val[31]}}, val};
   endfunction

endpackage

// File: rtl/imm_decode_comb.sv
// Pure combinational decode of an RV instruction word into an XLEN-wide
// immediate, its format code and an illegal flag.
module imm_decode_comb
   import imm_gen_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter bit EN_RV64I = (XLEN == 64)
) (
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm,
   output fmt_e            fmt,
   output logic            illegal
);

   logic [31:0] imm32;
   logic        sgn;

   always_comb begin
      imm32   = '0;
      sgn     = 1'b0;
      fmt     = FMT_NONE;
      illegal = 1'b0;
      if (instr[1:0] != 2'b11) begin
         illegal = 1'b1;
      end else begin
         case (instr[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_FENCE: begin
               fmt   = FMT_I;
               sgn   = 1'b1;
               imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_OP_IMM_32: begin
               if (EN_RV64I) begin
                  fmt   = FMT_I;
                  sgn   = 1'b1;
                  imm32 = {{20{instr[31]}}, instr[31:20]};
               end else begin
                  illegal = 1'b1;
               end
            end
            OPC_STORE: begin
               fmt   = FMT_S;
               sgn   = 1'b1;
               imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OPC_BRANCH: begin
               fmt   = FMT_B;
               sgn   = 1'b1;
               imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
               fmt   = FMT_U;
               sgn   = 1'b1;
               imm32 = {instr[31:12], 12'b0};
            end
            OPC_JAL: begin
               fmt   = FMT_J;
               sgn   = 1'b1;
               imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OPC_SYSTEM: begin
               // funct3[2] selects the 5-bit zimm form over the 12-bit CSR address
               fmt   = FMT_CSR;
               imm32 = instr[14] ? {27'b0, instr[19:15]} : {20'b0, instr[31:20]};
            end
            default: illegal = 1'b1;
         endcase
      end
   end

   assign imm = XLEN'(extend_imm(imm32, sgn));

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: decode, then a main register M and
// a skid register K give full throughput with a registered in_ready_o.
//
// state    | meaning
// ST_EMPTY | M and K empty, out_valid_o low
// ST_ONE   | M holds the presented result, K empty
// ST_TWO   | M and K full, in_ready_o low
module imm_gen_stage
   import imm_gen_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int TAG_W    = 32,
   parameter bit EN_RV64I = (XLEN == 64)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [31:0]      instr_i,
   input  logic [TAG_W-1:0] tag_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [XLEN-1:0]  imm_o,
   output logic [2:0]       fmt_o,
   output logic             illegal_o,
   output logic [TAG_W-1:0] tag_o
);

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      fmt_e             fmt;
      logic             illegal;
      logic [TAG_W-1:0] tag;
   } entry_t;

   occ_e   state_q, state_d;
   logic   in_ready_q;
   logic   accept, xfer;
   logic   load_m_in, load_k_in, move_k;
   entry_t m_q, k_q, dec_e;

   logic [XLEN-1:0] dec_imm;
   fmt_e            dec_fmt;
   logic            dec_illegal;

   imm_decode_comb #(
      .XLEN     (XLEN),
      .EN_RV64I (EN_RV64I)
   ) u_decode (
      .instr   (instr_i),
      .imm     (dec_imm),
      .fmt     (dec_fmt),
      .illegal (dec_illegal)
   );

   assign dec_e  = '{imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal, tag: tag_i};
   assign accept = in_valid_i && in_ready_q;
   assign xfer   = (state_q != ST_EMPTY) && out_ready_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != ST_TWO);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: if (accept) state_d = ST_ONE;
         ST_ONE: begin
            if (accept && !xfer)      state_d = ST_TWO;
            else if (!accept && xfer) state_d = ST_EMPTY;
         end
         ST_TWO:   if (xfer) state_d = ST_ONE;
         default:  state_d = ST_EMPTY;
      endcase
   end

   always_comb begin
      load_m_in = 1'b0;
      load_k_in = 1'b0;
      move_k    = 1'b0;
      case (state_q)
         ST_EMPTY: load_m_in = accept;
         ST_ONE: begin
            load_m_in = accept && xfer;
            load_k_in = accept && !xfer;
         end
         ST_TWO:   move_k = xfer;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         m_q <= '0;
         k_q <= '0;
      end else begin
         if (load_m_in)   m_q <= dec_e;
         else if (move_k) m_q <= k_q;
         if (load_k_in)   k_q <= dec_e;
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = (state_q != ST_EMPTY);
   assign imm_o       = m_q.imm;
   assign fmt_o       = m_q.fmt;
   assign illegal_o   = m_q.illegal;
   assign tag_o       = m_q.tag;

endmodule
